// File: rtl/key_operand_entry.sv
// Pushbutton front end: synchronizes and debounces four active-low keys, generates
// press/auto-repeat events, and maintains operands a, b and opcode op with an update strobe.
module key_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned MAX_DIGIT       = 9
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] op,
  output logic       update,
  output logic [3:0] held
);

  localparam int unsigned MaxDr  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                     : REPEAT_DELAY;
  localparam int unsigned MaxCnt = (MaxDr > REPEAT_PERIOD) ? MaxDr : REPEAT_PERIOD;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] RdLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RpLast  = CntW'(REPEAT_PERIOD - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [3:0]      MaxD    = 4'(MAX_DIGIT);

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StHeld,
    StRepeat,
    StReleaseWait
  } key_state_e;

  logic [3:0]      sync1_q, sync2_q;
  key_state_e      state_q [4];
  key_state_e      state_d [4];
  logic [CntW-1:0] cnt_q   [4];
  logic [CntW-1:0] cnt_d   [4];
  logic [3:0]      ev;
  logic [3:0]      held_q, held_d;
  logic [3:0]      a_q, a_d, b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic            update_q, update_d;

  // Two-flop synchronizer; preset to released so reset never looks like a press
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debounce / repeat next-state; ev is a single-cycle press or repeat event
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ev[i]      = 1'b0;
      case (state_q[i])
        StIdle: begin
          cnt_d[i] = '0;
          if (!sync2_q[i]) state_d[i] = StPressWait;
        end
        StPressWait: begin
          if (sync2_q[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DebLast) begin
            ev[i]      = 1'b1;
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StHeld: begin
          if (sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = '0;
          end else if (i != 3) begin
            // The clear key never auto-repeats, so it simply parks here
            if (cnt_q[i] == RdLast) begin
              ev[i]      = 1'b1;
              state_d[i] = StRepeat;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CntOne;
            end
          end
        end
        StRepeat: begin
          if (sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == RpLast) begin
            ev[i]    = 1'b1;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StReleaseWait: begin
          if (!sync2_q[i]) begin
            // Release bounce: back to held with a fresh repeat delay, no event
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DebLast) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] != StIdle) && (state_d[i] != StPressWait);
    end
  end

  // Per-key FSM state, counters and debounced held flags
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      held_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      held_q <= held_d;
    end
  end

  // Operand/opcode next values; clear wins, other keys combine in one cycle
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    if (ev[3]) begin
      a_d  = '0;
      b_d  = '0;
      op_d = '0;
    end else begin
      if (ev[0]) op_d = op_q + 2'd1;
      if (ev[1]) b_d = (b_q == MaxD) ? 4'd0 : b_q + 4'd1;
      if (ev[2]) a_d = (a_q == MaxD) ? 4'd0 : a_q + 4'd1;
    end
    update_d = (a_d != a_q) || (b_d != b_q) || (op_d != op_q);
  end

  // Operand registers and update strobe
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      update_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      update_q <= update_d;
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign op     = op_q;
  assign update = update_q;
  assign held   = held_q;

endmodule
